world_clock_zone_engine: RTL and testbench

//  Parametrised multi-zone world-clock converter. Replaces the fixed 4-zone combinational hour map.
//  On each TIME_VALID pulse, latches local HOUR:MIN and converts it for NUM_ZONES programmable zones.

---
 rtl/world_clock_pkg.sv | 48 ++++
 rtl/world_clock_zone_engine_wrap.sv | 44 ++++
 rtl/world_clock_zone_engine.sv | 200 ++++++++++++++++++++
 tb/tb_world_clock_zone_engine.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/world_clock_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : world_clock_pkg
//  Description : Shared constants, day-shift encodings, FSM state type,
//                per-zone result record and reset offset table for the
//                multi-zone world-clock converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package world_clock_pkg;

  localparam int MIN_PER_DAY = 1440;
  localparam int MIN_PER_HR  = 60;
  localparam int MIN_PER_QH  = 15;

  // Width of the signed minute-of-day working value. Covers
  // 23:59 + 63*15 = 2384 and 0:00 - 64*15 = -960 with margin.
  localparam int T_W = 13;

  localparam logic [1:0] DAY_SAME = 2'b00;
  localparam logic [1:0] DAY_NEXT = 2'b01;
  localparam logic [1:0] DAY_PREV = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  typedef struct packed {
    logic [6:0] hour;
    logic [6:0] min;
    logic [1:0] day;
  } zone_res_t;

  // Offset (quarter-hours) loaded into table entry idx on reset.
  function automatic int default_ofs(input int idx);
    case (idx)
      0:       return 8;    // +2:00
      1:       return -4;   // -1:00
      2:       return -56;  // -14:00
      3:       return -36;  // -9:00
      default: return 0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/world_clock_zone_engine_wrap.sv
`default_nettype none
// ============================================================================
//  Module      : zone_time_wrap
//  Description : Folds a signed minute-of-day value back into one day and
//                splits it into hour / minute plus a day-shift code.
//                Purely combinational.
//  Ports       : t    in  T_W  signed minutes, |t - legal range| < 1 day
//                hour out 7    0..23
//                min  out 7    0..59
//                day  out 2    DAY_SAME / DAY_NEXT / DAY_PREV
//  Revision    : 1.0 - initial release
// ============================================================================
module zone_time_wrap
  import world_clock_pkg::*;
(
  input  logic signed [T_W-1:0] t,
  output logic [6:0]            hour,
  output logic [6:0]            min,
  output logic [1:0]            day
);

  localparam logic signed [T_W-1:0] c_day = T_W'(MIN_PER_DAY);
  localparam logic signed [T_W-1:0] c_hr  = T_W'(MIN_PER_HR);

  logic signed [T_W-1:0] w_adj;

  // A single correction is enough because the offset magnitude never
  // reaches a full day.
  always_comb begin
    w_adj = t;
    day   = DAY_SAME;
    if (t[T_W-1]) begin
      w_adj = t + c_day;
      day   = DAY_PREV;
    end else if (t >= c_day) begin
      w_adj = t - c_day;
      day   = DAY_NEXT;
    end
    hour = 7'(w_adj / c_hr);
    min  = 7'(w_adj % c_hr);
  end

endmodule
`default_nettype wire

// File: rtl/world_clock_zone_engine.sv
`default_nettype none
// ============================================================================
//  Module      : world_clock_zone_engine
//  Description : Converts a latched local time into NUM_ZONES programmable
//                time zones (signed quarter-hour offsets) with a two-stage
//                pipeline, one zone per cycle, and commits the whole result
//                set at once for display through sel.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                hour, min           local time (0..23, 0..59)
//                time_valid          pulse: sample time and start a scan
//                wr_en/wr_idx/wr_ofs offset table write port
//                sel                 zone shown on hour_w/min_w/day_w
//                hour_w/min_w/day_w  committed result of zone sel
//                busy, done          scan in progress / set committed
//                err                 sticky [0] illegal time, [1] busy hit
//  Revision    : 1.0 - initial release
// ============================================================================
module world_clock_zone_engine
  import world_clock_pkg::*;
#(
  parameter int NUM_ZONES = 4,
  parameter int OFS_W     = 7,
  parameter int IDX_W     = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       hour,
  input  logic [6:0]       min,
  input  logic             time_valid,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFS_W-1:0] wr_ofs,
  input  logic [IDX_W-1:0] sel,
  output logic [6:0]       hour_w,
  output logic [6:0]       min_w,
  output logic [1:0]       day_w,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err
);

  state_t                r_state;
  state_t                w_next;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_legal;
  logic                  w_start;
  logic                  w_last_issue;

  logic [6:0]            r_hour;
  logic [6:0]            r_min;
  logic [IDX_W-1:0]      r_issue_idx;
  logic                  r_s1_valid;
  logic [IDX_W-1:0]      r_s1_idx;
  logic signed [T_W-1:0] r_s1_t;
  logic signed [T_W-1:0] w_ofs_ext;
  logic signed [T_W-1:0] w_base;
  logic signed [T_W-1:0] w_t;

  logic signed [OFS_W-1:0] r_table [NUM_ZONES];
  zone_res_t             r_work   [NUM_ZONES];
  zone_res_t             r_commit [NUM_ZONES];
  logic [6:0]            w_wrap_hour;
  logic [6:0]            w_wrap_min;
  logic [1:0]            w_wrap_day;
  logic [1:0]            r_err;

  assign w_legal      = (hour <= 7'd23) && (min <= 7'd59);
  // A new scan may also start straight out of COMMIT; the commit copy
  // happens on the same edge, before stage 2 touches the working array.
  assign w_start      = time_valid && w_legal &&
                        ((r_state == IDLE) || (r_state == COMMIT));
  assign w_last_issue = (r_issue_idx == IDX_W'(NUM_ZONES - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) w_next = SCAN;
      end
      SCAN: begin
        w_busy = 1'b1;
        if (w_last_issue) w_next = DRAIN;
      end
      DRAIN: begin
        // The last zone sits in stage 1 during this cycle and retires
        // into the working array on the closing edge.
        w_busy = 1'b1;
        w_next = COMMIT;
      end
      COMMIT: begin
        w_done = 1'b1;
        w_next = w_start ? SCAN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign busy = w_busy;
  assign done = w_done;
  assign err  = r_err;

  // ------------------------------------------------ sample and issue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hour      <= '0;
      r_min       <= '0;
      r_issue_idx <= '0;
    end else if (w_start) begin
      r_hour      <= hour;
      r_min       <= min;
      r_issue_idx <= '0;
    end else if (r_state == SCAN) begin
      r_issue_idx <= r_issue_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= '0;
    end else if (time_valid) begin
      if (w_busy)        r_err[1] <= 1'b1;
      else if (!w_legal) r_err[0] <= 1'b1;
    end
  end

  // --------------------------------------------------- offset table
  // Stage 1 reads the registered entry, so a write landing on the entry
  // being issued only shows up in the following scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ZONES; i++) r_table[i] <= OFS_W'(default_ofs(i));
    end else if (wr_en && (32'(wr_idx) < NUM_ZONES)) begin
      r_table[wr_idx] <= wr_ofs;
    end
  end

  // -------------------------------------------------------- stage 1
  assign w_ofs_ext = T_W'(r_table[r_issue_idx]);
  assign w_base    = $signed(T_W'(r_hour) * T_W'(MIN_PER_HR) + T_W'(r_min));
  assign w_t       = w_base + w_ofs_ext * $signed(T_W'(MIN_PER_QH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_t     <= '0;
    end else begin
      r_s1_valid <= (r_state == SCAN);
      r_s1_idx   <= r_issue_idx;
      r_s1_t     <= w_t;
    end
  end

  // -------------------------------------------------------- stage 2
  zone_time_wrap u_wrap (
    .t    (r_s1_t),
    .hour (w_wrap_hour),
    .min  (w_wrap_min),
    .day  (w_wrap_day)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ZONES; i++) r_work[i] <= '0;
    end else if (r_s1_valid) begin
      r_work[r_s1_idx] <= '{hour: w_wrap_hour, min: w_wrap_min, day: w_wrap_day};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ZONES; i++) r_commit[i] <= '0;
    end else if (r_state == COMMIT) begin
      for (int i = 0; i < NUM_ZONES; i++) r_commit[i] <= r_work[i];
    end
  end

  // --------------------------------------------------- display mux
  always_comb begin
    hour_w = '0;
    min_w  = '0;
    day_w  = '0;
    if (32'(sel) < NUM_ZONES) begin
      hour_w = r_commit[sel].hour;
      min_w  = r_commit[sel].min;
      day_w  = r_commit[sel].day;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_world_clock_zone_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_world_clock_zone_engine
//  Description : Directed bench for world_clock_zone_engine. Expected zone
//                results are queued when a scan is launched and popped while
//                sweeping sel after the result set is committed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_world_clock_zone_engine;

  localparam int N = 4;

  typedef struct packed {
    logic [6:0] h;
    logic [6:0] m;
    logic [1:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] hour;
  logic [6:0] min;
  logic       time_valid;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic [6:0] wr_ofs;
  logic [1:0] sel;
  logic [6:0] hour_w;
  logic [6:0] min_w;
  logic [1:0] day_w;
  logic       busy;
  logic       done;
  logic [1:0] err;

  exp_t q[$];
  exp_t last_exp[N];
  int   bt[N];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  world_clock_zone_engine dut (
    .clk        (clk),
    .rst        (rst),
    .hour       (hour),
    .min        (min),
    .time_valid (time_valid),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_ofs     (wr_ofs),
    .sel        (sel),
    .hour_w     (hour_w),
    .min_w      (min_w),
    .day_w      (day_w),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int h, input int m, input int ofs);
    int   t;
    exp_t e;
    t   = h * 60 + m + ofs * 15;
    e.d = 2'b00;
    if (t < 0) begin
      t   = t + 1440;
      e.d = 2'b11;
    end else if (t >= 1440) begin
      t   = t - 1440;
      e.d = 2'b01;
    end
    e.h = 7'(t / 60);
    e.m = 7'(t % 60);
    return e;
  endfunction

  task automatic push_lit(input int h, input int m, input logic [1:0] d);
    exp_t e;
    e.h = 7'(h);
    e.m = 7'(m);
    e.d = d;
    q.push_back(e);
  endtask

  task automatic push_model(input int h, input int m);
    for (int i = 0; i < N; i++) q.push_back(model(h, m, bt[i]));
  endtask

  task automatic default_table();
    bt[0] = 8; bt[1] = -4; bt[2] = -56; bt[3] = -36;
  endtask

  // Pops one expectation per zone and compares it with the committed output.
  task automatic check_zones(input string tag);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      sel = 2'(i);
      #1;
      if (q.size() == 0) begin
        e = '0;
        check($sformatf("%s_z%0d_queue_empty", tag, i), 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check($sformatf("%s_z%0d", tag, i), {16'd0, hour_w, min_w, day_w}, {16'd0, e});
      end
      last_exp[i] = e;
    end
  endtask

  task automatic check_last(input string tag);
    for (int i = 0; i < N; i++) begin
      sel = 2'(i);
      #1;
      check($sformatf("%s_z%0d", tag, i), {16'd0, hour_w, min_w, day_w}, {16'd0, last_exp[i]});
    end
  endtask

  // Launches a scan. dbl repeats time_valid (with a different time) in the
  // first busy cycle; wr_at > 0 writes the table in that busy cycle, where
  // busy cycle k issues zone k-1.
  task automatic do_scan(input string tag, input int h, input int m, input bit dbl,
                         input int wr_at, input int widx, input int wofs);
    int lat;
    lat = 0;
    @(negedge clk);
    hour = 7'(h); min = 7'(m); time_valid = 1'b1;
    @(negedge clk);
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    for (int k = 1; k < 30; k++) begin
      if (k > 1) @(negedge clk);
      time_valid = dbl && (k == 1);
      if (dbl && (k == 1)) begin
        hour = 7'd5; min = 7'd5;
      end
      wr_en  = (k == wr_at);
      wr_idx = 2'(widx);
      wr_ofs = 7'(wofs);
      if (done) begin
        lat = k;
        break;
      end
    end
    time_valid = 1'b0;
    wr_en      = 1'b0;
    check({tag, "_done_latency"}, 32'(lat), 32'(N + 2));
    @(negedge clk);
    check({tag, "_done_single"}, 32'(done), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; hour = '0; min = '0; time_valid = 1'b0;
    wr_en = 1'b0; wr_idx = '0; wr_ofs = '0; sel = '0;
    default_table();
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err",  32'(err),  32'd0);
    for (int i = 0; i < N; i++) last_exp[i] = '0;
    check_last("rst_out");
    rst = 1'b0;

    // Defaults, 23:30
    push_lit(1, 30, 2'b01); push_lit(22, 30, 2'b00);
    push_lit(9, 30, 2'b00); push_lit(14, 30, 2'b00);
    do_scan("t1", 23, 30, 1'b0, 0, 0, 0);
    check_zones("t1");

    // Defaults, 00:10, previous-day wraps
    push_lit(2, 10, 2'b00); push_lit(23, 10, 2'b11);
    push_lit(10, 10, 2'b11); push_lit(15, 10, 2'b11);
    do_scan("t2", 0, 10, 1'b0, 0, 0, 0);
    check_zones("t2");

    // z1 = +5:30, 20:45
    @(negedge clk);
    wr_en = 1'b1; wr_idx = 2'd1; wr_ofs = 7'd22;
    @(negedge clk);
    wr_en = 1'b0;
    bt[1] = 22;
    push_lit(22, 45, 2'b00); push_lit(2, 15, 2'b01);
    push_lit(6, 45, 2'b00);  push_lit(11, 45, 2'b00);
    do_scan("t3", 20, 45, 1'b0, 0, 0, 0);
    check_zones("t3");

    // Illegal hour, then illegal minute
    @(negedge clk);
    hour = 7'd24; min = 7'd0; time_valid = 1'b1;
    @(negedge clk);
    time_valid = 1'b0;
    check("t4_hour_err", 32'(err), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check("t4_hour_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    check_last("t4_hour_hold");
    hour = 7'd10; min = 7'd60; time_valid = 1'b1;
    @(negedge clk);
    time_valid = 1'b0;
    check("t4_min_err", 32'(err), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check("t4_min_busy", 32'(busy), 32'd0);
      check("t4_min_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    check_last("t4_min_hold");

    // Back-to-back time_valid: second is ignored and flagged
    push_model(12, 0);
    do_scan("t5a", 12, 0, 1'b1, 0, 0, 0);
    check("t5a_err", 32'(err), 32'd3);
    check_zones("t5a");

    // Write z2 in its own issue cycle: old offset this scan, new next scan
    push_model(12, 0);
    do_scan("t5b", 12, 0, 1'b0, 3, 2, 4);
    bt[2] = 4;
    check_zones("t5b");
    push_model(12, 0);
    do_scan("t5c", 12, 0, 1'b0, 0, 0, 0);
    check_zones("t5c");

    // Reset in the middle of a scan
    @(negedge clk);
    hour = 7'd23; min = 7'd30; time_valid = 1'b1;
    @(negedge clk);
    time_valid = 1'b0;
    @(negedge clk);
    check("t6_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_busy_after", 32'(busy), 32'd0);
    check("t6_err_after",  32'(err),  32'd0);
    for (int k = 0; k < 8; k++) begin
      check("t6_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) last_exp[i] = '0;
    check_last("t6_out_zero");
    default_table();
    push_lit(1, 30, 2'b01); push_lit(22, 30, 2'b00);
    push_lit(9, 30, 2'b00); push_lit(14, 30, 2'b00);
    do_scan("t6", 23, 30, 1'b0, 0, 0, 0);
    check_zones("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
